// File: rtl/speed_bar_cluster_pkg.sv
// Shared widths, colour indices and ramp state encoding for the speed bar cluster.
package speed_cluster_pkg;

  localparam int unsigned COORD_W = 12;
  localparam int unsigned PIX_W   = 4;

  localparam logic [PIX_W-1:0] COL_LIT_EDGE = 4'd4;
  localparam logic [PIX_W-1:0] COL_LIT_FILL = 4'd3;
  localparam logic [PIX_W-1:0] COL_DIM      = 4'd1;
  localparam logic [PIX_W-1:0] COL_PEAK     = 4'hF;
  localparam logic [PIX_W-1:0] COL_NONE     = 4'd0;

  typedef enum logic [1:0] {
    StIdle,
    StRise,
    StFall
  } ramp_state_e;

endpackage

// File: rtl/speed_bar_cluster_if.sv
// Control, speed and pixel-probe signals of the speed bar cluster overlay layer.
interface speed_bar_cluster_if #(
  parameter int unsigned N_SEG   = 33,
  parameter int unsigned SPEED_W = 8
);
  import speed_cluster_pkg::*;

  localparam int unsigned LC_W = $clog2(N_SEG + 1);

  logic               i_animate;
  logic               i_speed_valid;
  logic [SPEED_W-1:0] i_speed;
  logic               i_peak_en;
  logic [COORD_W-1:0] i_x;
  logic [COORD_W-1:0] i_y;
  logic [PIX_W-1:0]   o_pix;
  logic [LC_W-1:0]    o_lit_count;
  logic               o_overspeed;

  modport master (
    output i_animate, i_speed_valid, i_speed, i_peak_en, i_x, i_y,
    input  o_pix, o_lit_count, o_overspeed
  );

  modport slave (
    input  i_animate, i_speed_valid, i_speed, i_peak_en, i_x, i_y,
    output o_pix, o_lit_count, o_overspeed
  );

endinterface

// File: rtl/speed_bar_cluster_ramp.sv
// Displayed-speed ramp toward the target, lit-segment count, peak hold and overspeed blink.
module speed_bar_ramp
  import speed_cluster_pkg::*;
#(
  parameter int unsigned N_SEG        = 33,
  parameter int unsigned SPEED_W      = 8,
  parameter int unsigned BASE         = 5,
  parameter int unsigned STEP_X2      = 5,
  parameter int unsigned RISE_STEP    = 2,
  parameter int unsigned FALL_STEP    = 1,
  parameter int unsigned HOLD_FRAMES  = 30,
  parameter int unsigned REDLINE      = 80,
  parameter int unsigned BLINK_FRAMES = 15,
  localparam int unsigned LC_W        = $clog2(N_SEG + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               animate_i,
  input  logic               speed_valid_i,
  input  logic [SPEED_W-1:0] speed_i,
  input  logic               peak_en_i,
  output logic [LC_W-1:0]    lit_o,
  output logic [LC_W-1:0]    peak_o,
  output logic               blink_phase_o,
  output logic [LC_W-1:0]    lit_count_o,
  output logic               overspeed_o
);

  localparam int unsigned HOLD_W  = $clog2(HOLD_FRAMES + 1);
  localparam int unsigned BLINK_W = $clog2(BLINK_FRAMES + 1);

  localparam logic [SPEED_W:0]   RISE_INC  = (SPEED_W + 1)'(RISE_STEP);
  localparam logic [SPEED_W:0]   FALL_DEC  = (SPEED_W + 1)'(FALL_STEP);
  localparam logic [HOLD_W-1:0]  HOLD_INIT = HOLD_W'(HOLD_FRAMES);
  localparam logic [BLINK_W-1:0] BLINK_TOP = BLINK_W'(BLINK_FRAMES - 1);

  ramp_state_e        state_q, state_d;
  logic [SPEED_W-1:0] target_q, target_d;
  logic [SPEED_W-1:0] disp_q, disp_d;
  logic [SPEED_W:0]   rise_sum, fall_floor;
  logic [LC_W-1:0]    lit;
  logic [LC_W-1:0]    peak_q, peak_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic [LC_W-1:0]    lit_count_q;
  logic               overspeed_q;

  // The tick acts on the registered target, so a same-cycle load only affects later ticks.
  always_comb begin
    disp_d     = disp_q;
    rise_sum   = {1'b0, disp_q} + RISE_INC;
    fall_floor = {1'b0, target_q} + FALL_DEC;
    if (animate_i) begin
      case (state_q)
        StRise:  disp_d = (rise_sum >= {1'b0, target_q}) ? target_q : rise_sum[SPEED_W-1:0];
        StFall:  disp_d = ({1'b0, disp_q} <= fall_floor) ? target_q
                                                          : disp_q - FALL_DEC[SPEED_W-1:0];
        default: disp_d = disp_q;
      endcase
    end
    target_d = speed_valid_i ? speed_i : target_q;
    state_d  = StIdle;
    if (disp_d < target_d) begin
      state_d = StRise;
    end else if (disp_d > target_d) begin
      state_d = StFall;
    end
  end

  always_comb begin
    lit = '0;
    for (int k = 0; k < int'(N_SEG); k++) begin
      if (32'(disp_q) >= BASE + (32'(k) * STEP_X2) / 2) begin
        lit = lit + LC_W'(1);
      end
    end
  end

  always_comb begin
    peak_d = peak_q;
    hold_d = hold_q;
    if (lit > peak_q) begin
      peak_d = lit;
      hold_d = HOLD_INIT;
    end else if (animate_i) begin
      if (hold_q != '0) begin
        hold_d = hold_q - HOLD_W'(1);
      end else if (peak_q > lit) begin
        peak_d = peak_q - LC_W'(1);
      end
    end
    if (!peak_en_i) begin
      peak_d = lit;
    end
  end

  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (!overspeed_q) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (animate_i) begin
      if (blink_cnt_q == BLINK_TOP) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      target_q      <= '0;
      disp_q        <= '0;
      peak_q        <= '0;
      hold_q        <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      lit_count_q   <= '0;
      overspeed_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      disp_q        <= disp_d;
      peak_q        <= peak_d;
      hold_q        <= hold_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      lit_count_q   <= lit;
      overspeed_q   <= (32'(disp_q) >= REDLINE);
    end
  end

  assign lit_o         = lit;
  assign peak_o        = peak_q;
  assign blink_phase_o = blink_phase_q;
  assign lit_count_o   = lit_count_q;
  assign overspeed_o   = overspeed_q;

endmodule

// File: rtl/speed_bar_cluster.sv
// Speed bar overlay: hit-tests the pixel against N_SEG outlined dashes and registers a colour.
module speed_bar_cluster
  import speed_cluster_pkg::*;
#(
  parameter int unsigned N_SEG        = 33,
  parameter int unsigned SPEED_W      = 8,
  parameter int unsigned BASE         = 5,
  parameter int unsigned STEP_X2      = 5,
  parameter int unsigned X0           = 515,
  parameter int unsigned Y0           = 351,
  parameter int unsigned PITCH        = 15,
  parameter int unsigned Y_STEP       = 1,
  parameter int unsigned HALF_W       = 6,
  parameter int unsigned HALF_H       = 74,
  parameter int unsigned BORDER       = 3,
  parameter int unsigned RISE_STEP    = 2,
  parameter int unsigned FALL_STEP    = 1,
  parameter int unsigned HOLD_FRAMES  = 30,
  parameter int unsigned REDLINE      = 80,
  parameter int unsigned BLINK_FRAMES = 15
) (
  input logic             i_clk,
  input logic             i_rst_n,
  speed_bar_cluster_if.slave bus
);

  localparam int unsigned LC_W = $clog2(N_SEG + 1);

  logic [LC_W-1:0]  lit, peak, lit_count;
  logic             blink_phase, overspeed;
  logic             hit, interior;
  logic [LC_W-1:0]  hit_k;
  logic [PIX_W-1:0] pix_d, pix_q;
  int               xi, yi, cx, cy;

  speed_bar_ramp #(
    .N_SEG        (N_SEG),
    .SPEED_W      (SPEED_W),
    .BASE         (BASE),
    .STEP_X2      (STEP_X2),
    .RISE_STEP    (RISE_STEP),
    .FALL_STEP    (FALL_STEP),
    .HOLD_FRAMES  (HOLD_FRAMES),
    .REDLINE      (REDLINE),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_ramp (
    .clk_i         (i_clk),
    .rst_ni        (i_rst_n),
    .animate_i     (bus.i_animate),
    .speed_valid_i (bus.i_speed_valid),
    .speed_i       (bus.i_speed),
    .peak_en_i     (bus.i_peak_en),
    .lit_o         (lit),
    .peak_o        (peak),
    .blink_phase_o (blink_phase),
    .lit_count_o   (lit_count),
    .overspeed_o   (overspeed)
  );

  // Scan from the highest segment down so the lowest overlapping index wins.
  always_comb begin
    hit      = 1'b0;
    interior = 1'b0;
    hit_k    = '0;
    xi       = int'(bus.i_x);
    yi       = int'(bus.i_y);
    cx       = 0;
    cy       = 0;
    for (int k = int'(N_SEG) - 1; k >= 0; k--) begin
      cx = int'(X0) - k * int'(PITCH);
      cy = int'(Y0) - k * int'(Y_STEP);
      if (xi > cx - int'(HALF_W) && xi < cx + int'(HALF_W) &&
          yi > cy - int'(HALF_H) && yi < cy + int'(HALF_H)) begin
        hit      = 1'b1;
        hit_k    = LC_W'(k);
        interior = xi > cx - int'(HALF_W) + int'(BORDER) &&
                   xi < cx + int'(HALF_W) - int'(BORDER) &&
                   yi > cy - int'(HALF_H) + int'(BORDER) &&
                   yi < cy + int'(HALF_H) - int'(BORDER);
      end
    end
  end

  always_comb begin
    pix_d = COL_NONE;
    if (hit) begin
      if (hit_k < lit) begin
        pix_d = interior ? (blink_phase ? COL_NONE : COL_LIT_FILL) : COL_LIT_EDGE;
      end else if (bus.i_peak_en && peak > lit && hit_k == peak - LC_W'(1)) begin
        pix_d = COL_PEAK;
      end else begin
        pix_d = interior ? COL_NONE : COL_DIM;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pix_q <= COL_NONE;
    end else begin
      pix_q <= pix_d;
    end
  end

  assign bus.o_pix       = pix_q;
  assign bus.o_lit_count = lit_count;
  assign bus.o_overspeed = overspeed;

endmodule

// File: tb/tb_speed_bar_cluster.sv
// Directed bench for speed_bar_cluster: ramp, lit count, peak hold, blink and pixel colours.
module tb_speed_bar_cluster;
  import speed_cluster_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_bad = 0;

  speed_bar_cluster_if bus ();

  speed_bar_cluster dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One frame tick followed by three idle cycles so registered outputs settle.
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.i_animate = 1'b1;
      step(1);
      bus.i_animate = 1'b0;
      step(3);
    end
  endtask

  task automatic load_speed(input int spd);
    bus.i_speed       = 8'(spd);
    bus.i_speed_valid = 1'b1;
    step(1);
    bus.i_speed_valid = 1'b0;
  endtask

  task automatic probe(input string tag, input int x, input int y, input int exp);
    bus.i_x = 12'(x);
    bus.i_y = 12'(y);
    step(1);
    check(tag, int'(bus.o_pix), exp);
  endtask

  task automatic check_status(input string tag, input int lit, input int ovs);
    check({tag, "_lit"}, int'(bus.o_lit_count), lit);
    check({tag, "_ovs"}, int'(bus.o_overspeed), ovs);
  endtask

  initial begin
    bus.i_animate     = 1'b0;
    bus.i_speed_valid = 1'b0;
    bus.i_speed       = '0;
    bus.i_peak_en     = 1'b0;
    bus.i_x           = 12'd0;
    bus.i_y           = 12'd0;

    // Reset state and geometry at speed 0
    step(2);
    check_status("rst", 0, 0);
    check("rst_pix", int'(bus.o_pix), 0);
    rst_n = 1'b1;
    step(1);
    probe("seg0_edge_dim", 510, 351, 1);
    probe("seg0_fill_dim", 515, 351, 0);
    probe("seg0_strict_x", 509, 351, 0);

    // Rise to 20: L = 7
    load_speed(20);
    tick_n(10);
    check_status("rise20", 7, 0);
    probe("seg6_lit_fill", 425, 345, 3);
    probe("seg7_unlit_fill", 410, 344, 0);

    // Fall to 10 with peak hold, then decay of the marker
    bus.i_peak_en = 1'b1;
    load_speed(10);
    tick_n(10);
    check("fall10_lit", int'(bus.o_lit_count), 3);
    probe("peak_seg6_t10", 425, 345, 15);
    tick_n(20);
    probe("peak_seg6_t30", 425, 345, 15);
    tick_n(1);
    probe("seg6_after_decay", 425, 345, 0);
    probe("peak_seg5_t31", 440, 346, 15);
    tick_n(2);
    probe("peak_seg3_t33", 470, 348, 15);
    bus.i_peak_en = 1'b0;
    probe("peak_off_seg3", 470, 348, 0);

    // Overspeed and blink of seg0 interior
    load_speed(90);
    tick_n(45);
    check_status("os90", 33, 1);
    probe("blink_t45", 515, 351, 3);
    tick_n(4);
    probe("blink_t49", 515, 351, 3);
    tick_n(1);
    probe("blink_t50", 515, 351, 0);
    tick_n(14);
    probe("blink_t64", 515, 351, 0);
    tick_n(1);
    probe("blink_t65", 515, 351, 3);

    // Same-cycle load and tick: that tick uses the old target of 0
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    bus.i_speed       = 8'd40;
    bus.i_speed_valid = 1'b1;
    bus.i_animate     = 1'b1;
    step(1);
    bus.i_speed_valid = 1'b0;
    bus.i_animate     = 1'b0;
    step(3);
    tick_n(2);
    check("same_cyc_disp4", int'(bus.o_lit_count), 0);
    tick_n(1);
    check("same_cyc_disp6", int'(bus.o_lit_count), 1);
    probe("seg0_lit_edge", 510, 351, 4);
    tick_n(1);
    check("disp8_lit", int'(bus.o_lit_count), 2);

    // Reset mid-ramp aborts: everything back to 0, target cleared
    rst_n = 1'b0;
    step(1);
    check_status("midrst", 0, 0);
    check("midrst_pix", int'(bus.o_pix), 0);
    rst_n = 1'b1;
    tick_n(5);
    check("post_rst_lit", int'(bus.o_lit_count), 0);
    probe("post_rst_edge", 510, 351, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/speed_bar_cluster.md
Name: speed_bar_cluster

Overview:
- Parametrised successor to the fixed 33-dash speed cluster: draws N_SEG outlined dash segments and lights them from a live speed value.
- Displayed speed ramps toward the target on frame ticks; adds peak-hold marker and overspeed blink.
- Sits in the HDMI pixel pipeline; its 4-bit colour index is summed/muxed with other overlay layers.

Parameters:
- N_SEG, 33, number of dash segments
- SPEED_W, 8, speed input width (unsigned mph)
- BASE, 5, threshold of segment 0
- STEP_X2, 5, threshold step in half-mph; thr_k = BASE + floor(k*STEP_X2/2)
- X0, 515, centre x of segment 0
- Y0, 351, centre y of segment 0
- PITCH, 15, x decrement per segment
- Y_STEP, 1, y decrement per segment
- HALF_W, 6, segment half width
- HALF_H, 74, segment half height
- BORDER, 3, outline thickness
- RISE_STEP, 2, mph added per tick when rising
- FALL_STEP, 1, mph removed per tick when falling
- HOLD_FRAMES, 30, peak hold ticks
- REDLINE, 80, overspeed threshold (mph)
- BLINK_FRAMES, 15, ticks per blink phase

Ports:
- i_clk  in  1  pixel clock
- i_rst_n  in  1  synchronous active-low reset
- i_animate  in  1  one-cycle frame tick
- i_speed_valid  in  1  latch i_speed as target this cycle
- i_speed  in  SPEED_W  target speed
- i_peak_en  in  1  enable peak-hold marker
- i_x  in  12  current pixel x
- i_y  in  12  current pixel y
- o_pix  out  4  colour index, registered
- o_lit_count  out  $clog2(N_SEG+1)  lit segments L
- o_overspeed  out  1  disp >= REDLINE

Behaviour:
- Reset (i_rst_n low at i_clk edge): target, disp, peak P, hold counter, blink counter, blink phase, o_pix, o_lit_count, o_overspeed all 0. Reset mid-ramp aborts immediately.
- Target: loaded on i_speed_valid; no ready signal, always accepted.
- Ramp FSM: IDLE (disp==target), RISE (disp<target), FALL (disp>target); state evaluated every cycle, disp changes only on i_animate.
  - RISE: disp = min(disp+RISE_STEP, target).
  - FALL: disp = max(disp-FALL_STEP, target). Arithmetic in SPEED_W+1 bits, no wrap.
- i_speed_valid and i_animate in the same cycle: the tick uses the old target; the new target is latched the same edge.
- L = count of k with disp >= thr_k, recomputed from registered disp; o_lit_count and o_overspeed are registered from disp.
- Peak hold:
  - If L > P: P <= L and hold <= HOLD_FRAMES (every cycle, not tick-gated).
  - Else on tick: if hold > 0, hold decrements; else if P > L, P decrements by 1.
  - If i_peak_en = 0: P tracks L and no marker is drawn.
- Blink: while o_overspeed, the counter advances per tick; phase toggles and the counter clears at BLINK_FRAMES. When not overspeed, counter and phase are 0.
- Geometry: segment k centre cx = X0 - k*PITCH, cy = Y0 - k*Y_STEP.
  - Inside: cx-HALF_W < x < cx+HALF_W and cy-HALF_H < y < cy+HALF_H, all strict.
  - Interior: the same test with every bound inset by BORDER.
  - Overlap: the lowest k wins.
- Colour of the hit segment:
  - Lit (k < L): edge 4, interior 3 (0 when blink phase = 1).
  - Peak (i_peak_en, P > L, k = P-1): edge and interior 0xF.
  - Unlit: edge 1, interior 0.
  - No hit: 0.
- Latency: o_pix is valid 1 cycle after i_x/i_y.

Decomposition:
- Package speed_cluster_pkg: COORD_W=12, PIX_W=4, colour constants COL_LIT_EDGE=4, COL_LIT_FILL=3, COL_DIM=1, COL_PEAK=4'hF, COL_NONE=0, and the ramp state enum.
- Sub-module speed_bar_ramp: target/disp FSM, L, peak/hold, blink.
- Top level: hit-test and colour register.

Test Plan:
- Reset, speed 0: (510,351) -> o_pix=1 next cycle; (515,351) -> 0; (509,351) -> 0 (strict bound).
- Speed 20 valid, 10 ticks: disp=20, L=7; seg6 centre (425,345) -> 3; seg7 centre (410,344) -> 0.
- Then speed 10, i_peak_en=1: disp=10 after 10 ticks, L=3; (425,345) -> 0xF until 30 ticks after last rise, then P decays 7->3 at 1 per tick; with i_peak_en=0 -> 0.
- Speed 90: after 45 ticks disp=90, L=33, o_overspeed=1; seg0 interior alternates 3/0 every 15 ticks.
- i_speed_valid + i_animate same cycle from disp 0, target 0, new speed 40: disp stays 0 that tick; next tick disp=2.
- Rising to 40, i_rst_n low when disp=8: next cycle disp=0, L=0, o_pix=0, o_overspeed=0.
